// File: rtl/invtrig_pkg.sv
// Shared types and constants for the inverse sine/cosine search, including the
// first-quadrant SenLUT contents (Q1.31 sine, 0..90 degrees, saturated at 90).
package invtrig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        ROUND,
        MAP,
        DONE
    } state_e;

    localparam logic [31:0] DEG_90  = 32'd90;
    localparam logic [31:0] DEG_360 = 32'd360;
    localparam logic [31:0] MAG_SAT = 32'h7FFF_FFFF;

    typedef logic [31:0] lut_t [0:90];

    localparam int unsigned SIN_E7 [0:90] = '{
              0,  174524,  348995,  523360,  697565,  871557, 1045285, 1218693, 1391731, 1564345,
        1736482, 1908090, 2079117, 2249511, 2419219, 2588190, 2756374, 2923717, 3090170, 3255682,
        3420201, 3583679, 3746066, 3907311, 4067366, 4226183, 4383711, 4539905, 4694716, 4848096,
        5000000, 5150381, 5299193, 5446390, 5591929, 5735764, 5877853, 6018150, 6156615, 6293204,
        6427876, 6560590, 6691306, 6819984, 6946584, 7071068, 7193398, 7313537, 7431448, 7547096,
        7660444, 7771460, 7880108, 7986355, 8090170, 8191520, 8290376, 8386706, 8480481, 8571673,
        8660254, 8746197, 8829476, 8910065, 8987940, 9063078, 9135455, 9205049, 9271839, 9335804,
        9396926, 9455186, 9510565, 9563048, 9612617, 9659258, 9702957, 9743701, 9781476, 9816272,
        9848078, 9876883, 9902681, 9925462, 9945219, 9961947, 9975641, 9986295, 9993908, 9998477,
        10000000
    };

    // Scaled once at elaboration: round(sin * 2^31), with sin(90) clipped to the positive max.
    function automatic lut_t build_lut();
        lut_t t;
        logic [63:0] p;
        for (int unsigned i = 0; i <= 90; i++) begin
            p = (64'(SIN_E7[i]) * 64'd2147483648 + 64'd5000000) / 64'd10000000;
            t[i] = (p > 64'h7FFF_FFFF) ? MAG_SAT : p[31:0];
        end
        return t;
    endfunction

    localparam lut_t SEN_TBL = build_lut();

    function automatic logic [31:0] senlut(input int unsigned deg);
        logic [6:0] idx;
        idx = (deg > 32'd90) ? 7'd90 : 7'(deg);
        return SEN_TBL[idx];
    endfunction

endpackage

// File: rtl/invtrig_map.sv
// Quadrant mapping of a first-quadrant search result to a 0..359 degree angle.
module invtrig_map
    import invtrig_pkg::*;
#(
    parameter int unsigned AW = 7
) (
    input  logic          op_i,
    input  logic          sign_i,
    input  logic [AW-1:0] acc_i,
    output logic [31:0]   angle_o
);

    logic [31:0] acc32;

    always_comb begin
        acc32 = 32'(acc_i);
        unique case ({op_i, sign_i})
            2'b00:   angle_o = acc32;
            2'b01:   angle_o = (acc32 == '0) ? '0 : DEG_360 - acc32;
            2'b10:   angle_o = DEG_90 - acc32;
            default: angle_o = DEG_90 + acc32;
        endcase
    end

endmodule

// File: rtl/senlut.sv
// First-quadrant sine table: angle 0..90 in, Q1.31 value out; addresses above 90 read entry 90.
module SenLUT
    import invtrig_pkg::*;
#(
    parameter int unsigned AW = 7
) (
    input  logic [AW-1:0] angle_i,
    output logic [31:0]   value_o
);

    always_comb begin
        value_o = senlut(32'(angle_i));
    end

endmodule

// File: rtl/inverse_trig_lut.sv
// Multi-cycle arcsine/arccosine by binary search over SenLUT, valid/ready on both sides.
// INVTRIG_ROUND_NEAREST_EN adds a ROUND state that snaps to the nearer table entry.
module inverse_trig_lut
    import invtrig_pkg::*;
#(
    parameter int unsigned ITER    = 7,
    parameter int unsigned MAX_DEG = 90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op_selector,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] angle
);

    localparam int unsigned BW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [ITER-1:0] MAX_A = ITER'(MAX_DEG);

    state_e          state_q;
    logic            op_q, sign_q;
    logic [31:0]     mag_q, mag_d;
    logic [ITER-1:0] acc_q, cand;
    logic [BW-1:0]   bit_q;
    logic            in_ready_q, out_valid_q;
    logic [31:0]     angle_q;
    logic [ITER-1:0] lut_addr;
    logic [31:0]     lut_val, map_angle;
    logic            cand_ok;
`ifdef INVTRIG_ROUND_NEAREST_EN
    logic [31:0]     lo_q;
    logic            round_up;
`endif

    always_comb begin
        mag_d = value;
        if (value[31]) begin
            mag_d = (value == 32'h8000_0000) ? MAG_SAT : (~value + 32'd1);
        end
        cand     = acc_q | (ITER'(1) << bit_q);
        lut_addr = cand;
`ifdef INVTRIG_ROUND_NEAREST_EN
        // ROUND reuses the single table port to fetch the entry just above the floor
        if (state_q == ROUND) begin
            lut_addr = acc_q + ITER'(1);
        end
`endif
    end

    SenLUT #(.AW(ITER)) u_senlut (
        .angle_i (lut_addr),
        .value_o (lut_val)
    );

    assign cand_ok = (cand <= MAX_A) && (lut_val <= mag_q);

`ifdef INVTRIG_ROUND_NEAREST_EN
    // floor guarantees lo_q <= mag_q < lut_val here, so both differences are non-negative
    assign round_up = (acc_q < MAX_A) && ((lut_val - mag_q) < (mag_q - lo_q));
`endif

    invtrig_map #(.AW(ITER)) u_map (
        .op_i    (op_q),
        .sign_i  (sign_q),
        .acc_i   (acc_q),
        .angle_o (map_angle)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            acc_q       <= '0;
            bit_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            angle_q     <= '0;
`ifdef INVTRIG_ROUND_NEAREST_EN
            lo_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q       <= op_selector;
                        sign_q     <= value[31];
                        mag_q      <= mag_d;
                        acc_q      <= '0;
                        bit_q      <= BW'(ITER - 1);
                        in_ready_q <= 1'b0;
`ifdef INVTRIG_ROUND_NEAREST_EN
                        lo_q       <= '0;
`endif
                        state_q    <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (cand_ok) begin
                        acc_q <= cand;
`ifdef INVTRIG_ROUND_NEAREST_EN
                        lo_q  <= lut_val;
`endif
                    end
                    if (bit_q == '0) begin
`ifdef INVTRIG_ROUND_NEAREST_EN
                        state_q <= ROUND;
`else
                        state_q <= MAP;
`endif
                    end else begin
                        bit_q <= bit_q - BW'(1);
                    end
                end
`ifdef INVTRIG_ROUND_NEAREST_EN
                ROUND: begin
                    if (round_up) begin
                        acc_q <= acc_q + ITER'(1);
                    end
                    state_q <= MAP;
                end
`endif
                MAP: begin
                    angle_q     <= map_angle;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign angle     = angle_q;

endmodule

// File: tb/tb_inverse_trig_lut.sv
// Directed bench for inverse_trig_lut; expected angles are hand-derived from the quadrant rules.
module tb_inverse_trig_lut;
    import invtrig_pkg::*;

`ifdef INVTRIG_ROUND_NEAREST_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_selector = 1'b0;
    logic [31:0] value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] angle;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inverse_trig_lut #(.ITER(7), .MAX_DEG(90)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_selector (op_selector),
        .value       (value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .angle       (angle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] neg(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    task automatic start_req(input logic op, input logic [31:0] v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_req", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        op_selector = op;
        value       = v;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_accept", {31'b0, out_valid}, 32'd0);
        check("in_ready_after_accept", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic op, input logic [31:0] v, input logic [31:0] exp);
        int lat;
        start_req(op, v);
        wait_result(lat);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_angle"}, angle, exp);
        accept();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        logic seen;

        #12;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_angle", angle, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run("asin_30",      1'b0, senlut(30),      32'd30);
        run("asin_neg30",   1'b0, neg(senlut(30)), 32'd330);
        run("asin_zero",    1'b0, 32'd0,           32'd0);
        run("acos_60",      1'b1, senlut(60),      32'd30);
        run("acos_neg60",   1'b1, neg(senlut(60)), 32'd150);
        run("acos_zero",    1'b1, 32'd0,           32'd90);
        run("asin_max",     1'b0, 32'h7FFF_FFFF,   32'd90);
        run("asin_min",     1'b0, 32'h8000_0000,   32'd270);
        run("acos_max",     1'b1, 32'h7FFF_FFFF,   32'd0);
        run("asin_44p1",    1'b0, senlut(44) + 32'd1, 32'd44);
`ifdef INVTRIG_ROUND_NEAREST_EN
        run("asin_45m1",    1'b0, senlut(45) - 32'd1, 32'd45);
`else
        run("asin_45m1",    1'b0, senlut(45) - 32'd1, 32'd44);
`endif

        // result held while consumer stalls
        start_req(1'b0, senlut(30));
        wait_result(lat);
        check("hold_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_angle", angle, 32'd30);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        accept();

        // a second request during SEARCH must be ignored
        start_req(1'b0, senlut(60));
        @(negedge clk);
        check("busy_in_ready", {31'b0, in_ready}, 32'd0);
        op_selector = 1'b1;
        value       = neg(senlut(30));
        in_valid    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        wait_result(lat);
        check("busy_latency", 32'(lat), 32'(LAT - 3));
        check("busy_angle", angle, 32'd60);
        accept();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("busy_no_second_result", {31'b0, seen}, 32'd0);

        // reset during the fourth SEARCH cycle aborts without a result
        start_req(1'b0, senlut(60));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_angle", angle, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", {31'b0, seen}, 32'd0);

        run("after_abort", 1'b1, senlut(30), 32'd60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inverse_trig_lut.md
Name: inverse_trig_lut

Overview:
- Inverse of the sine/cosine LUT path: takes a sine/cosine value and returns the integer-degree angle, 0..359.
- Op 0 = arcsine, op 1 = arccosine.
- Uses an iterative successive-approximation (binary) search over the existing SenLUT first-quadrant table (angle 0..90 in, 32-bit value out, monotonic non-decreasing).
- Sits beside the LUT block in the datapath as a multi-cycle unit with a valid/ready handshake.

Parameters:
- ITER, 7, search iterations (covers 0..127, clipped to MAX_DEG).
- MAX_DEG, 90, last valid first-quadrant table index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- op_selector  in  1  0 = arcsine, 1 = arccosine
- value  in  32  signed two's complement, SenLUT output format
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- angle  out  32  result angle in degrees, 0..359

Behaviour:
- Reset and interface:
  - One clock; reset is asynchronous and active-high.
  - Reset values: state IDLE, in_ready=1, out_valid=0, angle=0, all internal registers 0.
  - Reset mid-search aborts the operation with no output.
- States: IDLE, SEARCH, [ROUND], MAP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op, sign = value[31] and mag = |value|.
  - mag saturates to 32'h7FFF_FFFF when value = 32'h8000_0000.
  - Clear acc and set bit = 6, then go to SEARCH.
- SEARCH (one cycle per bit, ITER cycles total):
  - cand = acc | (1<<bit).
  - If cand <= MAX_DEG and SenLUT(cand) <= mag, then acc = cand.
  - After bit 0, go to MAP (or ROUND when the optional feature is enabled).
  - Result: acc = largest a in 0..90 with SenLUT(a) <= mag, i.e. a floor.
  - mag >= SenLUT(90) gives 90.
- MAP (single cycle, registers angle):
  - asin, sign=0 -> acc.
  - asin, sign=1 -> (acc==0) ? 0 : 360-acc.
  - acos, sign=0 -> 90-acc.
  - acos, sign=1 -> 90+acc.
  - Then DONE.
- DONE:
  - out_valid=1, angle stable, in_ready=0.
  - On out_ready, go to IDLE with out_valid=0.
  - If out_ready is already high on the first DONE cycle, the transfer completes that cycle.
- Latency: in_valid accepted at cycle 0, out_valid at cycle ITER+2 (9); one more cycle with ROUND.
- Throughput: one request in flight. in_ready=0 outside IDLE, and in_valid is ignored there.
- Arithmetic widths:
  - Comparisons are unsigned 32-bit on mag.
  - Angle arithmetic is 32-bit unsigned.
  - No result exceeds 359.

Optional Feature:
- Macro: INVTRIG_ROUND_NEAREST_EN.
- Defined:
  - Adds a ROUND state between SEARCH and MAP.
  - If acc < 90 and (SenLUT(acc+1) - mag) < (mag - SenLUT(acc)), then acc = acc+1.
  - Ties keep acc.
  - Latency becomes 10.
- Undefined: no ROUND state, floor result, latency 9.

Decomposition:
- Package invtrig_pkg:
  - state enum (IDLE, SEARCH, ROUND, MAP, DONE).
  - constants DEG_90=90, DEG_360=360, MAG_SAT=32'h7FFF_FFFF.
- One sub-module, invtrig_map: the combinational quadrant mapping of (op, sign, acc) -> angle.
- SenLUT is instantiated directly, with one instance on the SEARCH candidate.
- With ROUND enabled, the SenLUT address is muxed to acc+1, sharing the instance.

Test Plan:
- Arcsine, exact table hit: op=0, value=SenLUT(30) -> out_valid at cycle 9, angle=30.
- Arcsine, negative input: op=0, value=-SenLUT(30) -> angle=330. value=0 -> angle=0 (not 360).
- Arccosine: op=1, value=SenLUT(60) -> angle=30. op=1, value=-SenLUT(60) -> angle=150. op=1, value=0 -> angle=90.
- Saturation: op=0, value=32'h7FFF_FFFF -> 90. op=0, value=32'h8000_0000 -> 270.
- Between table entries:
  - value = SenLUT(44) + 1 -> 44 without the macro.
  - With INVTRIG_ROUND_NEAREST_EN, value = SenLUT(45) - 1 -> 45.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles -> out_valid and angle stay stable.
  - in_valid during SEARCH is ignored.
  - Assert rst at cycle 4 of SEARCH -> out_valid=0 and in_ready=1 immediately, with no result produced.
